alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Front-end stage feeding the combinational ALU on the DE1-SoC board.
//  Collects operand A, operand B and the ALU control code from the switches, one push-button press per field.
//  Issues them to the ALU and registers the ALU result and flags.
//  Its outputs drive the HEX display organiser, which shows the result and the current step.
// PARAMETERS
//  DATA_W        8   operand/result width, in bits
//  CNTRL_W       3   ALU control code width, in bits
//  DEBOUNCE_CYC  16  consecutive stable cycles needed to accept a key level change (minimum 1)
// PORTS
//  clk          in   1        system clock
//  reset        in   1        synchronous, active-high reset
//  key_n        in   1        raw push-button, active-low, asynchronous to clk
//  sw_data      in   DATA_W   operand value from the switches
//  sw_cntrl     in   CNTRL_W  ALU control code from the switches
//  alu_a        out  DATA_W   registered operand A to the ALU
//  alu_b        out  DATA_W   registered operand B to the ALU
//  alu_cntrl    out  CNTRL_W  registered control code to the ALU
//  alu_valid    out  1        high for exactly the one EXEC cycle
//  alu_result   in   DATA_W   combinational ALU result
//  alu_neg, alu_zero, alu_ovf, alu_cout  in  1 each  combinational ALU flags
//  result_q     out  DATA_W   captured result
//  flags_q      out  4        captured flags, ordered {neg, zero, ovf, cout}
//  state_o      out  3        step code for the display
//  done         out  1        high while in SHOW
// BEHAVIOUR
//  Reset:
//   - Every output and internal register goes to 0; state goes to LOAD_A.
//   - The debouncer's stable level goes to 1 (released).
//  Key path:
//   - key_n passes through a 2-flop synchroniser, giving s2.
//   - A counter runs while s2 differs from the stable level and clears when they match.
//   - When the counter reaches DEBOUNCE_CYC-1 while s2 still differs, the stable level takes s2 and the counter clears.
//   - press is a 1-cycle pulse on the stable level's 1->0 transition. Release does nothing.
//   - A press that stays held yields exactly one pulse.
//   - Latency: if key_n is first sampled low at edge 1 and stays low, the FSM acts at edge 2+DEBOUNCE_CYC.
//   - A low glitch shorter than DEBOUNCE_CYC cycles (measured at s2) produces no press.
//  FSM (state_o encoding in brackets):
//   - LOAD_A [0]: on press, a <= sw_data and go to LOAD_B.
//   - LOAD_B [1]: on press, b <= sw_data and go to LOAD_OP.
//   - LOAD_OP [2]: on press, cntrl <= sw_cntrl and go to EXEC.
//   - EXEC [3]: lasts exactly 1 cycle with alu_valid=1. At its closing edge, result_q <= alu_result, flags_q <= {neg, zero, ovf, cout}, and state goes to SHOW. A press arriving in EXEC is discarded.
//   - SHOW [4]: done=1. On press, go to LOAD_A. result_q, flags_q, alu_a, alu_b and alu_cntrl keep their values until overwritten.
//   - Any other (illegal) encoding goes to LOAD_A on the next edge.
//  Other rules:
//   - Reset asserted mid-sequence has priority over press. Returns to LOAD_A with all registers cleared the same edge.
//   - alu_a, alu_b and alu_cntrl stay stable from their load until the next load of the same field.
//   - ALU inputs are therefore stable throughout EXEC.
//   - No arithmetic is done here. Widths pass through unchanged and flags are captured verbatim.
// STRUCTURE
//  Package alu_seq_pkg:
//   - state enum (LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4).
//   - Flag bit indices (NEG=3, ZERO=2, OVF=1, COUT=0).
//   - ALU control constants (PASS_B=000, ADD=010, SUB=011, AND=100, OR=101, XOR=110).
//  Sub-module key_debouncer (DEBOUNCE_CYC):
//   - Contains the synchroniser, counter and stable level.
//   - Outputs the press pulse.
//  The top level holds the FSM and the capture registers.
// TESTING  (bench: DEBOUNCE_CYC=4, behavioural ALU model, DATA_W=8)
//  1. Assert reset for 2 cycles -> all outputs 0, state_o=0, done=0, alu_valid=0.
//  2. Press with sw=05, then 03, then cntrl=010 (ADD) -> alu_valid high for exactly 1 cycle; result_q=08, flags_q=0000; state_o=4, done=1.
//  3. Sequence A=03, B=05, SUB -> result_q=FE, flags_q=1000. Then a press in SHOW -> state_o=0, done=0, result_q still FE.
//  4. key_n low for 3 cycles, then high -> no state change. key_n low for 4 cycles -> one advance.
//  5. Hold key_n low for 100 cycles, then release -> exactly one advance and nothing on release. Press edge lands at 2+4 edges after the first low sample.
//  6. Load A=AA and B=55, then assert reset while in LOAD_OP -> state_o=0, alu_a=00, alu_b=00 on the same edge.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  // Bit positions inside flags_q, ordered {neg, zero, ovf, cout}
  localparam int FLAG_NEG  = 3;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_COUT = 0;

  // ALU control codes understood by the downstream combinational ALU
  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

endpackage

// File: rtl/key_debouncer.sv
// Synchronises and debounces an active-low push-button and emits a single
// pulse per accepted press. The pulse is issued in the same cycle the stable
// level falls, so downstream logic acts on that edge.
module key_debouncer #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic             key_p0;
  logic             key_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Accept the synchronised level once it has differed for DEBOUNCE_CYC cycles
  assign accept = (key_p1 != stable) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));
  assign press  = accept && stable && !key_p1;

  // Two-flop synchroniser; resets to the released level so no false press follows reset
  always_ff @(posedge clk) begin
    if (reset) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= key_n;
      key_p1 <= key_p0;
    end
  end

  // Stability counter and debounced level
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (key_p1 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= key_p1;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and the ALU control code one button press at
// a time, issues them to the combinational ALU for one cycle and captures the
// result and flags for display.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CNTRL_W      = 3,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_n,
  input  logic [DATA_W-1:0]  sw_data,
  input  logic [CNTRL_W-1:0] sw_cntrl,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [CNTRL_W-1:0] alu_cntrl,
  output logic               alu_valid,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_neg,
  input  logic               alu_zero,
  input  logic               alu_ovf,
  input  logic               alu_cout,
  output logic [DATA_W-1:0]  result_q,
  output logic [3:0]         flags_q,
  output logic [2:0]         state_o,
  output logic               done
);

  state_t state_q;
  logic   press;

  key_debouncer #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .press (press)
  );

  assign state_o = state_q;

  // Step FSM with operand loads, one-cycle issue and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD_A;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cntrl <= '0;
      alu_valid <= 1'b0;
      result_q  <= '0;
      flags_q   <= '0;
      done      <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (press) begin
            alu_a   <= sw_data;
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (press) begin
            alu_b   <= sw_data;
            state_q <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (press) begin
            alu_cntrl <= sw_cntrl;
            alu_valid <= 1'b1;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          // Any press seen here is intentionally dropped
          result_q           <= alu_result;
          flags_q[FLAG_NEG]  <= alu_neg;
          flags_q[FLAG_ZERO] <= alu_zero;
          flags_q[FLAG_OVF]  <= alu_ovf;
          flags_q[FLAG_COUT] <= alu_cout;
          alu_valid          <= 1'b0;
          done               <= 1'b1;
          state_q            <= SHOW;
        end
        SHOW: begin
          if (press) begin
            done    <= 1'b0;
            state_q <= LOAD_A;
          end
        end
        default: begin
          alu_valid <= 1'b0;
          done      <= 1'b0;
          state_q   <= LOAD_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Bench for alu_operand_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int DW = 8;
  localparam int CW = 3;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_n;
  logic [DW-1:0] sw_data;
  logic [CW-1:0] sw_cntrl;
  logic [DW-1:0] alu_a, alu_b, alu_result, result_q;
  logic [CW-1:0] alu_cntrl;
  logic          alu_valid, alu_neg, alu_zero, alu_ovf, alu_cout, done;
  logic [3:0]    flags_q;
  logic [2:0]    state_o;

  typedef struct {
    logic [DW-1:0] res;
    logic [3:0]    flg;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   vcount = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(
    .DATA_W(DW), .CNTRL_W(CW), .DEBOUNCE_CYC(DB)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw_data(sw_data), .sw_cntrl(sw_cntrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cntrl(alu_cntrl), .alu_valid(alu_valid),
    .alu_result(alu_result), .alu_neg(alu_neg), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .alu_cout(alu_cout), .result_q(result_q), .flags_q(flags_q), .state_o(state_o),
    .done(done)
  );

  // Behavioural ALU: returns {neg, zero, ovf, cout, result}
  function automatic logic [DW+3:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [CW-1:0] op);
    logic [DW:0]   s;
    logic [DW-1:0] r;
    logic          c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[DW-1:0]; c = s[DW];
        v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 1'b1;
        r = s[DW-1:0]; c = s[DW];
        v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      default: r = b;
    endcase
    return {r[DW-1], (r == '0), v, c, r};
  endfunction

  always_comb begin
    {alu_neg, alu_zero, alu_ovf, alu_cout, alu_result} = alu_model(alu_a, alu_b, alu_cntrl);
  end

  // One debounced press: hold low 8 cycles, then release and let it settle
  task automatic press(input logic [DW-1:0] d, input logic [CW-1:0] c);
    sw_data = d; sw_cntrl = c; key_n = 1'b0;
    repeat (8) begin @(negedge clk); if (alu_valid) vcount++; end
    key_n = 1'b1;
    repeat (8) begin @(negedge clk); if (alu_valid) vcount++; end
  endtask

  // Full A/B/op sequence from LOAD_A, checked against the scoreboard
  task automatic run_seq(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] op,
                         input string nm);
    logic [DW+3:0] m;
    exp_t e, got;
    press(a, '0);
    press(b, '0);
    m = alu_model(a, b, op);
    e.res = m[DW-1:0]; e.flg = m[DW+3:DW];
    sb.push_back(e);
    vcount = 0;
    press('0, op);
    got = sb.pop_front();
    total++; if (vcount !== 1) $display("FAIL %s valid_cycles: got %0d want 1", nm, vcount); else passed++;
    total++; if (result_q !== got.res) $display("FAIL %s result_q: got %h want %h", nm, result_q, got.res); else passed++;
    total++; if (flags_q !== got.flg) $display("FAIL %s flags_q: got %b want %b", nm, flags_q, got.flg); else passed++;
    total++; if (state_o !== 3'd4 || done !== 1'b1) $display("FAIL %s show: got state %0d done %b want 4 1", nm, state_o, done); else passed++;
    total++; if (alu_a !== a || alu_b !== b || alu_cntrl !== op) $display("FAIL %s operands: got %h %h %b want %h %h %b", nm, alu_a, alu_b, alu_cntrl, a, b, op); else passed++;
  endtask

  task automatic test_reset;
    reset = 1'b1; key_n = 1'b1; sw_data = '0; sw_cntrl = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if (state_o !== 3'd0 || done !== 1'b0 || alu_valid !== 1'b0 || alu_a !== '0 || alu_b !== '0 ||
        alu_cntrl !== '0 || result_q !== '0 || flags_q !== '0)
      $display("FAIL reset: got st=%0d done=%b v=%b a=%h b=%h c=%b r=%h f=%b want all 0",
               state_o, done, alu_valid, alu_a, alu_b, alu_cntrl, result_q, flags_q);
    else passed++;
  endtask

  task automatic test_add;
    run_seq(8'h05, 8'h03, ALU_ADD, "add");
    total++; if (result_q !== 8'h08 || flags_q !== 4'b0000) $display("FAIL add_const: got %h %b want 08 0000", result_q, flags_q); else passed++;
  endtask

  task automatic test_sub_and_show;
    press('0, '0);
    total++; if (state_o !== 3'd0) $display("FAIL show_exit1: got %0d want 0", state_o); else passed++;
    run_seq(8'h03, 8'h05, ALU_SUB, "sub");
    total++; if (result_q !== 8'hFE || flags_q !== 4'b1000) $display("FAIL sub_const: got %h %b want fe 1000", result_q, flags_q); else passed++;
    press('0, '0);
    total++;
    if (state_o !== 3'd0 || done !== 1'b0 || result_q !== 8'hFE)
      $display("FAIL show_exit2: got st=%0d done=%b r=%h want 0 0 fe", state_o, done, result_q);
    else passed++;
  endtask

  task automatic test_glitch;
    sw_data = 8'h81; key_n = 1'b0;
    repeat (DB - 1) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (state_o !== 3'd0) $display("FAIL glitch: got state %0d want 0", state_o); else passed++;
    key_n = 1'b0;
    repeat (DB) @(negedge clk);
    key_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (state_o !== 3'd1 || alu_a !== 8'h81) $display("FAIL min_press: got st=%0d a=%h want 1 81", state_o, alu_a); else passed++;
  endtask

  task automatic test_hold;
    logic [DW+3:0] m;
    exp_t e, got;
    sw_data = 8'h7F; key_n = 1'b0;
    repeat (DB + 1) @(negedge clk);
    total++; if (state_o !== 3'd1) $display("FAIL latency_early: got state %0d want 1", state_o); else passed++;
    @(negedge clk);
    total++; if (state_o !== 3'd2 || alu_b !== 8'h7F) $display("FAIL latency_edge: got st=%0d b=%h want 2 7f", state_o, alu_b); else passed++;
    repeat (100 - DB - 2) @(negedge clk);
    total++; if (state_o !== 3'd2) $display("FAIL hold: got state %0d want 2", state_o); else passed++;
    key_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (state_o !== 3'd2) $display("FAIL release: got state %0d want 2", state_o); else passed++;
    m = alu_model(8'h81, 8'h7F, ALU_ADD);
    e.res = m[DW-1:0]; e.flg = m[DW+3:DW];
    sb.push_back(e);
    press('0, ALU_ADD);
    got = sb.pop_front();
    total++; if (result_q !== got.res || flags_q !== got.flg) $display("FAIL carry: got %h %b want %h %b", result_q, flags_q, got.res, got.flg); else passed++;
    total++; if (flags_q !== 4'b0101) $display("FAIL carry_const: got %b want 0101", flags_q); else passed++;
  endtask

  task automatic test_back_to_back;
    press('0, '0);
    run_seq(8'h7F, 8'h01, ALU_ADD, "ovf");
    total++; if (flags_q !== 4'b1010) $display("FAIL ovf_const: got %b want 1010", flags_q); else passed++;
    press('0, '0);
    run_seq(8'hF0, 8'h3C, ALU_XOR, "xor");
    press('0, '0);
    run_seq(8'h12, 8'h34, ALU_PASS_B, "passb");
  endtask

  task automatic test_mid_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    press(8'hAA, '0);
    press(8'h55, '0);
    total++; if (state_o !== 3'd2 || alu_a !== 8'hAA || alu_b !== 8'h55) $display("FAIL preload: got st=%0d a=%h b=%h want 2 aa 55", state_o, alu_a, alu_b); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (state_o !== 3'd0 || alu_a !== 8'h00 || alu_b !== 8'h00) $display("FAIL mid_reset: got st=%0d a=%h b=%h want 0 00 00", state_o, alu_a, alu_b); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and_show();
    test_glitch();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
